// File: rtl/rename_unit.sv
// N-wide register rename stage: circular free list, speculative RAT with
// same-group forwarding, registered output and valid/ready on both sides.
module rename_unit #(
  parameter int WIDTH     = 2,
  parameter int RET_WIDTH = 2,
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  localparam int AW = $clog2(ARCH_REGS),
  localparam int PW = $clog2(PHYS_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WIDTH-1:0]               in_valid,
  input  logic [WIDTH-1:0][AW-1:0]       in_rs1,
  input  logic [WIDTH-1:0][AW-1:0]       in_rs2,
  input  logic [WIDTH-1:0][AW-1:0]       in_rd,
  input  logic [WIDTH-1:0]               in_we,
  output logic                           in_ready,
  output logic [WIDTH-1:0]               out_valid,
  output logic [WIDTH-1:0][PW-1:0]       out_p_rs1,
  output logic [WIDTH-1:0][PW-1:0]       out_p_rs2,
  output logic [WIDTH-1:0][PW-1:0]       out_p_rd,
  output logic [WIDTH-1:0][PW-1:0]       out_p_old_rd,
  input  logic                           out_ready,
  input  logic [RET_WIDTH-1:0]           free_valid,
  input  logic [RET_WIDTH-1:0][PW-1:0]   free_preg,
  output logic [PW:0]                    free_count
);

  localparam int CAP = PHYS_REGS - ARCH_REGS;
  localparam logic [PW:0] CAP_W = (PW+1)'(CAP);
  localparam logic [PW:0] ONE_W = (PW+1)'(1);

  logic [PW-1:0] rat [ARCH_REGS];
  logic [PW-1:0] fl  [PHYS_REGS];
  logic [PW-1:0] head, tail;

  logic                          accept;
  logic [WIDTH-1:0]              writer;
  logic [WIDTH-1:0][PW-1:0]      p_rs1, p_rs2, p_rd, p_old;
  logic [PW:0]                   pops, pop_eff, pushes;
  logic [RET_WIDTH-1:0]          push_en;
  logic [RET_WIDTH-1:0][PW-1:0]  push_pos;
  logic                          overflow;

  // Readiness deliberately ignores in_we so in_ready never depends on inputs.
  assign in_ready = (!(|out_valid) || out_ready) && (free_count >= (PW+1)'(WIDTH));
  assign accept   = in_ready && (|in_valid);

  always_comb begin
    pops = '0;
    for (int j = 0; j < WIDTH; j++) begin
      writer[j] = in_valid[j] && in_we[j] && (in_rd[j] != '0);
      p_rs1[j]  = rat[in_rs1[j]];
      p_rs2[j]  = rat[in_rs2[j]];
      p_old[j]  = writer[j] ? rat[in_rd[j]] : '0;
      p_rd[j]   = '0;
      // Ascending scan so the highest earlier writer wins.
      for (int k = 0; k < j; k++) begin
        if (writer[k]) begin
          if (in_rd[k] == in_rs1[j]) p_rs1[j] = p_rd[k];
          if (in_rd[k] == in_rs2[j]) p_rs2[j] = p_rd[k];
          if (writer[j] && (in_rd[k] == in_rd[j])) p_old[j] = p_rd[k];
        end
      end
      if (writer[j]) begin
        p_rd[j] = fl[head + pops[PW-1:0]];
        pops    = pops + ONE_W;
      end
      if (!in_valid[j]) begin
        p_rs1[j] = '0;
        p_rs2[j] = '0;
      end
    end
  end

  assign pop_eff = accept ? pops : '0;

  always_comb begin
    pushes   = '0;
    overflow = 1'b0;
    for (int p = 0; p < RET_WIDTH; p++) begin
      push_en[p]  = 1'b0;
      push_pos[p] = tail + pushes[PW-1:0];
      if (free_valid[p] && (free_preg[p] != '0)) begin
        if ((free_count - pop_eff + pushes) >= CAP_W) begin
          overflow = 1'b1;
        end else begin
          push_en[p] = 1'b1;
          pushes     = pushes + ONE_W;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) rat[i] <= PW'(i);
      for (int i = 0; i < PHYS_REGS; i++) fl[i] <= (i < CAP) ? PW'(ARCH_REGS + i) : '0;
      head         <= '0;
      tail         <= PW'(CAP);
      free_count   <= CAP_W;
      out_valid    <= '0;
      out_p_rs1    <= '0;
      out_p_rs2    <= '0;
      out_p_rd     <= '0;
      out_p_old_rd <= '0;
    end else begin
      if (accept) begin
        for (int j = 0; j < WIDTH; j++) begin
          if (writer[j]) rat[in_rd[j]] <= p_rd[j];
        end
        head         <= head + pops[PW-1:0];
        out_valid    <= in_valid;
        out_p_rs1    <= p_rs1;
        out_p_rs2    <= p_rs2;
        out_p_rd     <= p_rd;
        out_p_old_rd <= p_old;
      end else if (out_ready) begin
        out_valid <= '0;
      end
      for (int p = 0; p < RET_WIDTH; p++) begin
        if (push_en[p]) fl[push_pos[p]] <= free_preg[p];
      end
      tail       <= tail + pushes[PW-1:0];
      free_count <= free_count - pop_eff + pushes;
    end
  end

  // Returning more registers than the list can hold means retire is broken.
  overflow_check: assert property (@(posedge clk) disable iff (!rst_n) !overflow);

endmodule

// File: tb/tb_rename_unit.sv
// Self-checking bench for rename_unit: a sequential-rename reference model
// compared every cycle, plus literal expectations for the directed scenarios.
module tb_rename_unit;

  localparam int W = 2, RW = 2, AR = 32, PR = 64, AW = 5, PW = 6;
  localparam int CAP = PR - AR;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0]           in_valid = '0;
  logic [W-1:0][AW-1:0]   in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [W-1:0]           in_we = '0;
  logic                   in_ready;
  logic [W-1:0]           out_valid;
  logic [W-1:0][PW-1:0]   out_p_rs1, out_p_rs2, out_p_rd, out_p_old_rd;
  logic                   out_ready = 1'b1;
  logic [RW-1:0]          free_valid = '0;
  logic [RW-1:0][PW-1:0]  free_preg = '0;
  logic [PW:0]            free_count;

  int checks = 0;
  int failures = 0;

  rename_unit #(.WIDTH(W), .RET_WIDTH(RW), .ARCH_REGS(AR), .PHYS_REGS(PR)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_we(in_we),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_p_rs1(out_p_rs1), .out_p_rs2(out_p_rs2),
    .out_p_rd(out_p_rd), .out_p_old_rd(out_p_old_rd), .out_ready(out_ready),
    .free_valid(free_valid), .free_preg(free_preg), .free_count(free_count)
  );

  always #5 clk = ~clk;

  // Reference model: rename slots one after another against a working map.
  int       m_rat [AR];
  int       tr    [AR];
  int       m_q   [$];
  logic [W-1:0] m_valid;
  int       e_rs1 [W], e_rs2 [W], e_rd [W], e_old [W];
  bit       m_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < AR; i++) m_rat[i] = i;
      m_q.delete();
      for (int i = AR; i < PR; i++) m_q.push_back(i);
      m_valid = '0;
    end else begin
      m_rdy = (m_valid == '0 || out_ready) && (m_q.size() >= W);
      if (m_rdy && in_valid != '0) begin
        tr = m_rat;
        for (int j = 0; j < W; j++) begin
          e_rs1[j] = tr[in_rs1[j]];
          e_rs2[j] = tr[in_rs2[j]];
          e_rd[j]  = 0;
          e_old[j] = 0;
          if (in_valid[j] && in_we[j] && in_rd[j] != 0) begin
            e_old[j] = tr[in_rd[j]];
            e_rd[j]  = m_q.pop_front();
            tr[in_rd[j]] = e_rd[j];
          end
        end
        m_rat   = tr;
        m_valid = in_valid;
      end else if (out_ready) begin
        m_valid = '0;
      end
      for (int p = 0; p < RW; p++) begin
        if (free_valid[p] && free_preg[p] != 0 && m_q.size() < CAP) m_q.push_back(int'(free_preg[p]));
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    checks++;
    if (actual !== 32'(expected)) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("cyc in_ready", 32'(in_ready),
                ((m_valid == '0 || out_ready) && m_q.size() >= W) ? 1 : 0);
    checkOutput("cyc free_count", 32'(free_count), m_q.size());
    checkOutput("cyc out_valid", 32'(out_valid), int'(m_valid));
    for (int j = 0; j < W; j++) begin
      if (m_valid[j]) begin
        checkOutput($sformatf("cyc slot%0d p_rs1", j), 32'(out_p_rs1[j]), e_rs1[j]);
        checkOutput($sformatf("cyc slot%0d p_rs2", j), 32'(out_p_rs2[j]), e_rs2[j]);
        checkOutput($sformatf("cyc slot%0d p_rd", j), 32'(out_p_rd[j]), e_rd[j]);
        checkOutput($sformatf("cyc slot%0d p_old_rd", j), 32'(out_p_old_rd[j]), e_old[j]);
      end
    end
  end

  task automatic setSlot(input int j, input bit v, input int rs1, input int rs2, input int rd, input bit we);
    in_valid[j] = v;
    in_rs1[j]   = AW'(rs1);
    in_rs2[j]   = AW'(rs2);
    in_rd[j]    = AW'(rd);
    in_we[j]    = we;
  endtask

  task automatic clearSlots();
    in_valid = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_we = '0;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkSlot(input string tag, input int j, input int rs1, input int rs2, input int rd, input int old);
    checkOutput({tag, " p_rs1"}, 32'(out_p_rs1[j]), rs1);
    checkOutput({tag, " p_rs2"}, 32'(out_p_rs2[j]), rs2);
    checkOutput({tag, " p_rd"}, 32'(out_p_rd[j]), rd);
    checkOutput({tag, " p_old_rd"}, 32'(out_p_old_rd[j]), old);
  endtask

  task automatic doReset();
    clearSlots();
    free_valid = '0;
    out_ready  = 1'b1;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    doReset();
    checkOutput("reset free_count", 32'(free_count), 32);
    checkOutput("reset out_valid", 32'(out_valid), 0);
    checkOutput("reset in_ready", 32'(in_ready), 1);

    // Single writer.
    setSlot(0, 1, 1, 2, 3, 1); setSlot(1, 0, 0, 0, 0, 0);
    applyStimulus(); clearSlots();
    checkOutput("single out_valid", 32'(out_valid), 1);
    checkSlot("single s0", 0, 1, 2, 32, 3);
    checkOutput("single free_count", 32'(free_count), 31);

    // Same-group forwarding.
    doReset();
    setSlot(0, 1, 0, 0, 5, 1); setSlot(1, 1, 5, 0, 5, 1);
    applyStimulus(); clearSlots();
    checkSlot("fwd s0", 0, 0, 0, 32, 5);
    checkSlot("fwd s1", 1, 32, 0, 33, 32);
    checkOutput("fwd free_count", 32'(free_count), 30);
    setSlot(0, 1, 5, 3, 0, 0);
    applyStimulus(); clearSlots();
    checkSlot("rat5 s0", 0, 33, 3, 0, 0);

    // x0 destination is a non-writer.
    setSlot(0, 1, 0, 0, 0, 1);
    applyStimulus(); clearSlots();
    checkOutput("x0 out_valid", 32'(out_valid), 1);
    checkSlot("x0 s0", 0, 0, 0, 0, 0);
    checkOutput("x0 free_count", 32'(free_count), 30);

    // Exhaust the free list, then reclaim and wrap.
    doReset();
    for (int g = 0; g < 16; g++) begin
      setSlot(0, 1, 0, 0, 1 + g, 1); setSlot(1, 1, 0, 0, 16 + g, 1);
      applyStimulus();
    end
    clearSlots();
    checkOutput("exhaust free_count", 32'(free_count), 0);
    checkOutput("exhaust in_ready", 32'(in_ready), 0);
    checkOutput("exhaust s0 p_rd", 32'(out_p_rd[0]), 62);
    checkOutput("exhaust s1 p_rd", 32'(out_p_rd[1]), 63);
    setSlot(0, 1, 1, 0, 1, 1);
    applyStimulus(); clearSlots();
    checkOutput("stalled out_valid", 32'(out_valid), 0);
    checkOutput("stalled in_ready", 32'(in_ready), 0);
    free_valid = 2'b11; free_preg[0] = 6'd40; free_preg[1] = 6'd41;
    applyStimulus(); free_valid = '0;
    checkOutput("reclaim free_count", 32'(free_count), 2);
    checkOutput("reclaim in_ready", 32'(in_ready), 1);
    setSlot(0, 1, 0, 0, 1, 1); setSlot(1, 1, 0, 0, 2, 1);
    applyStimulus(); clearSlots();
    checkSlot("wrap s0", 0, 0, 0, 40, 32);
    checkSlot("wrap s1", 1, 0, 0, 41, 34);
    checkOutput("wrap free_count", 32'(free_count), 0);
    free_valid = 2'b11; free_preg[0] = 6'd32; free_preg[1] = 6'd33;
    applyStimulus(); free_valid = '0;
    // Allocate and free in the same edge with head == tail.
    setSlot(0, 1, 0, 0, 3, 1); setSlot(1, 1, 0, 0, 4, 1);
    free_valid = 2'b11; free_preg[0] = 6'd34; free_preg[1] = 6'd35;
    applyStimulus(); clearSlots(); free_valid = '0;
    checkOutput("simul s0 p_rd", 32'(out_p_rd[0]), 32);
    checkOutput("simul s1 p_rd", 32'(out_p_rd[1]), 33);
    checkOutput("simul free_count", 32'(free_count), 2);
    setSlot(0, 1, 0, 0, 5, 1); setSlot(1, 1, 0, 0, 6, 1);
    applyStimulus(); clearSlots();
    checkOutput("after s0 p_rd", 32'(out_p_rd[0]), 34);
    checkOutput("after s1 p_rd", 32'(out_p_rd[1]), 35);
    checkOutput("after free_count", 32'(free_count), 0);

    // Back-pressure holds the output group.
    doReset();
    setSlot(0, 1, 1, 0, 7, 1); setSlot(1, 1, 0, 0, 8, 1);
    applyStimulus();
    out_ready = 1'b0;
    setSlot(0, 1, 7, 0, 9, 1); setSlot(1, 1, 8, 0, 10, 1);
    #1;
    checkOutput("hold in_ready", 32'(in_ready), 0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      checkSlot($sformatf("hold%0d s0", c), 0, 1, 0, 32, 7);
      checkOutput($sformatf("hold%0d s1 p_rd", c), 32'(out_p_rd[1]), 33);
      checkOutput($sformatf("hold%0d free_count", c), 32'(free_count), 30);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release in_ready", 32'(in_ready), 1);
    applyStimulus(); clearSlots();
    checkSlot("release s0", 0, 32, 0, 34, 9);
    checkSlot("release s1", 1, 33, 0, 35, 10);
    checkOutput("release free_count", 32'(free_count), 28);

    // Asynchronous reset mid-stream.
    doReset();
    for (int g = 0; g < 5; g++) begin
      setSlot(0, 1, 0, 0, 3, 1); setSlot(1, 1, 3, 0, 4, 1);
      applyStimulus();
    end
    checkOutput("midstream free_count", 32'(free_count), 22);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async out_valid", 32'(out_valid), 0);
    checkOutput("async free_count", 32'(free_count), 32);
    clearSlots();
    @(posedge clk);
    #1 rst_n = 1'b1;
    setSlot(0, 1, 3, 0, 0, 0);
    applyStimulus(); clearSlots();
    checkOutput("post reset p_rs1", 32'(out_p_rs1[0]), 3);
    checkOutput("post reset free_count", 32'(free_count), 32);

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
